// File: rtl/uart_pkg.sv
// Shared definitions for the UART block: scheduler state encoding, baud divisors
// and the byte width used across the transmitter path.
package uart_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned BAUD_DIV_TX = 5208;
  localparam int unsigned BAUD_DIV_RX = 651;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StSend     = 2'd1,
    StWaitNext = 2'd2
  } sched_state_e;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping around, reported both as a one-hot grant and as an index.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned GW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [GW-1:0]      gnt_idx,
  output logic               any_req
);

  // Operand is always below 2*NUM_REQ, so one conditional subtract suffices.
  function automatic int unsigned wrap_idx(int unsigned v);
    return (v >= NUM_REQ) ? (v - NUM_REQ) : v;
  endfunction

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    any_req = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!any_req && req[wrap_idx(32'(ptr) + k)]) begin
        any_req                       = 1'b1;
        grant[wrap_idx(32'(ptr) + k)] = 1'b1;
        gnt_idx                       = GW'(wrap_idx(32'(ptr) + k));
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx between NUM_REQ byte-stream requesters using round-robin
// arbitration that stays locked on a requester until its last byte or a stall timeout.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned IDLE_TIMEOUT = 52080,
  parameter int unsigned GW           = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [8*NUM_REQ-1:0]  req_data,
  input  logic [NUM_REQ-1:0]    req_last,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  tx_valid,
  output logic [BYTE_W-1:0]     tx_data,
  input  logic                  tx_ready,
  output logic [GW-1:0]         grant_id,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int unsigned CW = $clog2(IDLE_TIMEOUT);

  sched_state_e       state_q, state_d;
  logic               tx_valid_q, tx_valid_d;
  logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
  logic               timeout_q, timeout_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               last_q, last_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [GW-1:0]      arb_idx;
  logic               arb_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .grant   (arb_grant),
    .gnt_idx (arb_idx),
    .any_req (arb_any)
  );

  function automatic logic [GW-1:0] next_ptr(logic [GW-1:0] g);
    return (32'(g) == NUM_REQ - 1) ? '0 : g + 1'b1;
  endfunction

  always_comb begin
    state_d    = state_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    timeout_d  = 1'b0;
    cnt_d      = cnt_q;
    last_d     = last_q;
    req_ready  = '0;

    unique case (state_q)
      StIdle: begin
        if (arb_any) begin
          req_ready  = arb_grant;
          tx_data_d  = req_data[8*32'(arb_idx) +: 8];
          last_d     = req_last[arb_idx];
          tx_valid_d = 1'b1;
          grant_d    = arb_idx;
          state_d    = StSend;
        end
      end
      StSend: begin
        if (tx_valid_q && tx_ready) begin
          tx_valid_d = 1'b0;
          if (last_q) begin
            rr_ptr_d = next_ptr(grant_q);
            state_d  = StIdle;
          end else begin
            cnt_d   = '0;
            state_d = StWaitNext;
          end
        end
      end
      StWaitNext: begin
        // A byte arriving on the timeout cycle is still taken; capture has priority.
        if (req_valid[grant_q]) begin
          req_ready[grant_q] = 1'b1;
          tx_data_d          = req_data[8*32'(grant_q) +: 8];
          last_d             = req_last[grant_q];
          tx_valid_d         = 1'b1;
          state_d            = StSend;
        end else if (cnt_q == CW'(IDLE_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          rr_ptr_d  = next_ptr(grant_q);
          state_d   = StIdle;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
    end
  end

  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q != StIdle);
  assign timeout_err = timeout_q;

endmodule
